pong_ball_engine: RTL and testbench



---
 rtl/pong_ball_engine.sv | 178 +++++++++++++++++
 tb/tb_pong_ball_engine.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pong_ball_engine.sv
// Purpose: playfield engine that moves the ball and paddle on a frame tick, detects
//          wall and paddle collisions, keeps the score, and pulses sig_dead on a miss.
// Latency: every output is registered; a tick's effect appears on the following cycle.
// Backpressure: none; pulses are one cycle long and the controller samples them directly.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   ready_sig, start_sig  - pulses: full re-init (clears score) / new serve (keeps score)
//   play_sig, pause_sig   - levels: motion runs while play and not pause
//   left_sig, right_sig   - paddle move request pulses, honoured on the next tick
//   ball_x, ball_y        - ball top-left corner
//   paddle_x              - paddle left edge
//   score                 - paddle hits, saturating at 255
//   hit_sig, sig_dead     - one-cycle pulses for a paddle hit and for a miss
module pong_ball_engine #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int BALL_STEP   = 2,
  parameter int PADDLE_W    = 80,
  parameter int PADDLE_Y    = 460,
  parameter int PADDLE_STEP = 8,
  parameter int TICK_DIV    = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready_sig,
  input  logic       start_sig,
  input  logic       play_sig,
  input  logic       pause_sig,
  input  logic       left_sig,
  input  logic       right_sig,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_x,
  output logic [7:0] score,
  output logic       hit_sig,
  output logic       sig_dead
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  localparam logic [9:0] X0 = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] Y0 = 10'(SCREEN_H / 4);
  localparam logic [9:0] P0 = 10'((SCREEN_W - PADDLE_W) / 2);

  // Signed 11-bit copies of the geometry so that underflow below 0 and overflow
  // past the right/bottom edges are visible before clamping.
  localparam logic signed [10:0] W_S    = 11'(SCREEN_W);
  localparam logic signed [10:0] H_S    = 11'(SCREEN_H);
  localparam logic signed [10:0] SIZE_S = 11'(BALL_SIZE);
  localparam logic signed [10:0] STEP_S = 11'(BALL_STEP);
  localparam logic signed [10:0] PW_S   = 11'(PADDLE_W);
  localparam logic signed [10:0] PY_S   = 11'(PADDLE_Y);
  localparam logic signed [10:0] PS_S   = 11'(PADDLE_STEP);
  localparam logic signed [10:0] PMAX_S = 11'(SCREEN_W - PADDLE_W);
  localparam logic signed [10:0] ZERO_S = 11'sd0;
  localparam logic signed [10:0] ONE_S  = 11'sd1;

  logic          dx, dy, dead, lreq, rreq;
  logic [CW-1:0] cnt;

  logic                run, tick;
  logic signed [10:0]  xs, ys, px_s;
  logic signed [10:0]  nx, ny, pad_nx;
  logic                ndx, ndy;
  logic                crossing, hit, miss;

  assign run  = play_sig & ~pause_sig & ~dead;
  assign tick = run & (cnt == CNT_LAST);

  always_comb begin
    xs       = signed'({1'b0, ball_x});
    ys       = signed'({1'b0, ball_y});
    px_s     = signed'({1'b0, paddle_x});
    nx       = dx ? (xs + STEP_S) : (xs - STEP_S);
    ny       = dy ? (ys + STEP_S) : (ys - STEP_S);
    ndx      = dx;
    ndy      = dy;
    crossing = 1'b0;
    hit      = 1'b0;
    miss     = 1'b0;
    pad_nx   = px_s;

    // Horizontal walls: left check first, right check on the result.
    if (nx <= ZERO_S) begin
      nx  = ZERO_S;
      ndx = 1'b1;
    end
    if (nx + SIZE_S >= W_S) begin
      nx  = W_S - SIZE_S;
      ndx = 1'b0;
    end

    // Top wall only matters while moving up.
    if (!dy && ny <= ZERO_S) begin
      ny  = ZERO_S;
      ndy = 1'b1;
    end

    // The ball's bottom edge passes the paddle plane during this step.
    crossing = dy && (ys + SIZE_S <= PY_S) && (PY_S <= ny + SIZE_S);
    hit      = crossing && (nx <= px_s + PW_S - ONE_S) && (nx + SIZE_S - ONE_S >= px_s);
    if (hit) begin
      ny  = PY_S - SIZE_S;
      ndy = 1'b0;
    end else if (dy && (ny + SIZE_S >= H_S)) begin
      miss = 1'b1;
    end

    // Conflicting requests cancel; moves are clamped to the playfield.
    if (lreq ^ rreq) begin
      pad_nx = rreq ? (px_s + PS_S) : (px_s - PS_S);
      if (pad_nx < ZERO_S) pad_nx = ZERO_S;
      if (pad_nx > PMAX_S) pad_nx = PMAX_S;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || ready_sig) begin
      ball_x   <= X0;
      ball_y   <= Y0;
      paddle_x <= P0;
      dx       <= 1'b1;
      dy       <= 1'b1;
      score    <= 8'd0;
      hit_sig  <= 1'b0;
      sig_dead <= 1'b0;
      dead     <= 1'b0;
      lreq     <= 1'b0;
      rreq     <= 1'b0;
      cnt      <= '0;
    end else if (start_sig) begin
      ball_x   <= X0;
      ball_y   <= Y0;
      paddle_x <= P0;
      dx       <= 1'b1;
      dy       <= 1'b1;
      dead     <= 1'b0;
      hit_sig  <= 1'b0;
      sig_dead <= 1'b0;
      cnt      <= '0;
    end else begin
      hit_sig  <= 1'b0;
      sig_dead <= 1'b0;

      if (run) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

      // A tick consumes the pending requests; a request arriving on the tick
      // cycle itself is kept for the next tick rather than dropped.
      if (tick) begin
        lreq <= play_sig & left_sig;
        rreq <= play_sig & right_sig;
      end else if (play_sig) begin
        if (left_sig)  lreq <= 1'b1;
        if (right_sig) rreq <= 1'b1;
      end

      if (tick) begin
        paddle_x <= pad_nx[9:0];
        if (miss) begin
          dead     <= 1'b1;
          sig_dead <= 1'b1;
        end else begin
          ball_x <= nx[9:0];
          ball_y <= ny[9:0];
          dx     <= ndx;
          dy     <= ndy;
          if (hit) begin
            hit_sig <= 1'b1;
            if (score != 8'hFF) score <= score + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pong_ball_engine.sv
module tb_pong_ball_engine;

  logic       clk = 1'b0;
  logic       reset, ready_sig, start_sig, play_sig, pause_sig, left_sig, right_sig;
  logic [9:0] ball_x, ball_y, paddle_x;
  logic [7:0] score;
  logic       hit_sig, sig_dead;

  int checks = 0;
  int errors = 0;

  pong_ball_engine #(
    .SCREEN_W(64), .SCREEN_H(48), .BALL_SIZE(4), .BALL_STEP(2),
    .PADDLE_W(16), .PADDLE_Y(44), .PADDLE_STEP(4), .TICK_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .ready_sig(ready_sig), .start_sig(start_sig),
    .play_sig(play_sig), .pause_sig(pause_sig), .left_sig(left_sig),
    .right_sig(right_sig), .ball_x(ball_x), .ball_y(ball_y), .paddle_x(paddle_x),
    .score(score), .hit_sig(hit_sig), .sig_dead(sig_dead)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ball(input string tag, input int x, input int y);
    chk({tag, "_x"}, int'(ball_x), x);
    chk({tag, "_y"}, int'(ball_y), y);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (4 * n) step();
  endtask

  // Request pulse on the first cycle of a tick period; the period ends just after the tick edge.
  task automatic req_tick(input logic l, input logic r);
    left_sig  = l;
    right_sig = r;
    step();
    left_sig  = 1'b0;
    right_sig = 1'b0;
    repeat (3) step();
  endtask

  task automatic serve();
    start_sig = 1'b1;
    step();
    start_sig = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ready_sig = 1'b0; start_sig = 1'b0; play_sig = 1'b0;
    pause_sig = 1'b0; left_sig = 1'b0; right_sig = 1'b0;
    step(); step();
    chk_ball("reset_ball", 30, 12);
    chk("reset_paddle", int'(paddle_x), 24);
    chk("reset_score", int'(score), 0);
    chk("reset_hit", int'(hit_sig), 0);
    chk("reset_dead", int'(sig_dead), 0);
    reset = 1'b0;

    // Serve 1: first move, paddle right saturation, paddle hit, right wall.
    play_sig = 1'b1;
    serve();
    chk_ball("serve1_pos", 30, 12);
    repeat (3) step();
    chk_ball("serve1_pretick", 30, 12);
    step();
    chk_ball("serve1_first_move", 32, 14);
    chk("serve1_score", int'(score), 0);
    for (int i = 0; i < 7; i++) begin
      req_tick(1'b0, 1'b1);
      chk("pad_right", int'(paddle_x), (i < 6) ? 28 + 4 * i : 48);
    end
    chk_ball("serve1_t8", 46, 28);
    ticks(5);
    chk_ball("serve1_t13", 56, 38);
    chk("serve1_t13_hit", int'(hit_sig), 0);
    ticks(1);
    chk_ball("serve1_hit_pos", 58, 40);
    chk("serve1_hit_pulse", int'(hit_sig), 1);
    chk("serve1_hit_score", int'(score), 1);
    step();
    chk("serve1_hit_one_cycle", int'(hit_sig), 0);
    repeat (3) step();
    chk_ball("serve1_wall", 60, 38);
    ticks(1);
    chk_ball("serve1_after_wall", 58, 36);

    // Serve 2: score kept, paddle left saturation, conflicting requests.
    serve();
    chk("serve2_paddle", int'(paddle_x), 24);
    chk("serve2_score_kept", int'(score), 1);
    chk_ball("serve2_pos", 30, 12);
    for (int i = 0; i < 7; i++) begin
      req_tick(1'b1, 1'b0);
      chk("pad_left", int'(paddle_x), (i < 6) ? 20 - 4 * i : 0);
    end
    req_tick(1'b1, 1'b1);
    chk("pad_both", int'(paddle_x), 0);
    req_tick(1'b0, 1'b1);
    chk("pad_right_from0", int'(paddle_x), 4);

    // Serve 3: pause freezes ball and counter, then a miss at paddle 24.
    serve();
    ticks(5);
    chk_ball("serve3_t5", 40, 22);
    step(); step();
    pause_sig = 1'b1;
    repeat (20) step();
    chk_ball("pause_frozen", 40, 22);
    pause_sig = 1'b0;
    step();
    chk_ball("resume_pretick", 40, 22);
    step();
    chk_ball("resume_move", 42, 24);
    ticks(9);
    chk_ball("serve3_t15", 60, 42);
    chk("serve3_t15_dead", int'(sig_dead), 0);
    ticks(1);
    chk("miss_pulse", int'(sig_dead), 1);
    chk_ball("miss_pos", 60, 42);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("dead_no_pulse", int'(sig_dead), 0);
      chk("dead_no_hit", int'(hit_sig), 0);
    end
    chk_ball("dead_frozen", 60, 42);

    // Reset mid-serve.
    serve();
    ticks(3);
    chk_ball("serve4_t3", 36, 18);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_ball("midreset_ball", 30, 12);
    chk("midreset_paddle", int'(paddle_x), 24);
    chk("midreset_score", int'(score), 0);

    // Three hits, then ready clears the score.
    for (int k = 0; k < 3; k++) begin
      serve();
      for (int i = 0; i < 6; i++) req_tick(1'b0, 1'b1);
      ticks(8);
      chk("hit_loop_pulse", int'(hit_sig), 1);
      chk("hit_loop_score", int'(score), k + 1);
    end
    ready_sig = 1'b1;
    step();
    ready_sig = 1'b0;
    chk("ready_score", int'(score), 0);
    chk_ball("ready_ball", 30, 12);
    chk("ready_paddle", int'(paddle_x), 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
